ht_phase_scheduler: RTL and testbench

Sequences one hash-table engine through a multi-partition join, one partition at a time: clear, build, end-of-build, probe, drain. It sits between the partitioner output streams (build side and probe side) and the hash-table engine. It gates each stream into the engine only during that stream's phase, generates the engine's last-processed controls, and keeps per-run statistics.

---
 rtl/ht_phase_scheduler_if.sv | 63 ++++++
 rtl/ht_phase_scheduler.sv | 141 ++++++++++++++
 tb/tb_ht_phase_scheduler.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ht_phase_scheduler_if.sv
// Stream bundle between the partitioner outputs, the phase scheduler and the hash-table engine.
// The scheduler takes the master side; the environment (partitioner + engine) takes the slave side.
interface ht_phase_scheduler_if;
    logic        s_build_valid;
    logic        s_build_ready;
    logic [63:0] s_build_data;
    logic [31:0] s_build_hash;
    logic        s_build_last;

    logic        s_probe_valid;
    logic        s_probe_ready;
    logic [63:0] s_probe_data;
    logic [31:0] s_probe_hash;
    logic [63:0] s_probe_serial;
    logic        s_probe_last;

    logic        ht_clear_n;
    logic        ht_build_valid;
    logic [63:0] ht_build_data;
    logic [31:0] ht_build_hash;
    logic        ht_build_ready;
    logic        ht_build_last_processed;

    logic        ht_probe_valid;
    logic [63:0] ht_probe_data;
    logic [31:0] ht_probe_hash;
    logic [63:0] ht_probe_serial;
    logic        ht_probe_ready;
    logic        ht_probe_last_processed;

    logic        ht_out_valid;
    logic        ht_out_ready;
    logic        ht_out_was_joined;
    logic        ht_out_last_processed;

    modport master (
        input  s_build_valid, s_build_data, s_build_hash, s_build_last,
        output s_build_ready,
        input  s_probe_valid, s_probe_data, s_probe_hash, s_probe_serial, s_probe_last,
        output s_probe_ready,
        output ht_clear_n,
        output ht_build_valid, ht_build_data, ht_build_hash, ht_build_last_processed,
        input  ht_build_ready,
        output ht_probe_valid, ht_probe_data, ht_probe_hash, ht_probe_serial,
        output ht_probe_last_processed,
        input  ht_probe_ready,
        input  ht_out_valid, ht_out_ready, ht_out_was_joined, ht_out_last_processed
    );

    modport slave (
        output s_build_valid, s_build_data, s_build_hash, s_build_last,
        input  s_build_ready,
        output s_probe_valid, s_probe_data, s_probe_hash, s_probe_serial, s_probe_last,
        input  s_probe_ready,
        input  ht_clear_n,
        input  ht_build_valid, ht_build_data, ht_build_hash, ht_build_last_processed,
        output ht_build_ready,
        input  ht_probe_valid, ht_probe_data, ht_probe_hash, ht_probe_serial,
        input  ht_probe_last_processed,
        output ht_probe_ready,
        output ht_out_valid, ht_out_ready, ht_out_was_joined, ht_out_last_processed
    );
endinterface

// File: rtl/ht_phase_scheduler.sv
// Walks one hash-table engine through clear/build/probe/drain for each partition of a join run,
// gating the build and probe streams to their own phase and keeping per-run tuple/match totals.
module ht_phase_scheduler #(
    parameter int PART_W       = 8,
    parameter int CLEAR_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  start,
    input  logic [PART_W-1:0]     cfg_num_parts,
    ht_phase_scheduler_if.master  bus,
    output logic                  busy,
    output logic                  done,
    output logic [PART_W-1:0]     cur_part,
    output logic [CNT_W-1:0]      build_cnt,
    output logic [CNT_W-1:0]      probe_cnt,
    output logic [CNT_W-1:0]      match_cnt
);

    localparam int CLR_W = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_BUILD, S_BUILD_END, S_PROBE, S_DRAIN, S_DONE
    } state_t;

    state_t            state, state_next;
    logic [PART_W-1:0] num_parts;
    logic [CLR_W-1:0]  clr_cnt;
    logic              run_start, part_next, build_fire, probe_fire, match_fire;

    assign bus.ht_build_data   = bus.s_build_data;
    assign bus.ht_build_hash   = bus.s_build_hash;
    assign bus.ht_probe_data   = bus.s_probe_data;
    assign bus.ht_probe_hash   = bus.s_probe_hash;
    assign bus.ht_probe_serial = bus.s_probe_serial;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= S_IDLE;
        else         state <= state_next;
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_next                  = state;
        run_start                   = 1'b0;
        part_next                   = 1'b0;
        build_fire                  = 1'b0;
        probe_fire                  = 1'b0;
        busy                        = 1'b1;
        done                        = 1'b0;
        bus.ht_clear_n              = 1'b1;
        bus.s_build_ready           = 1'b0;
        bus.ht_build_valid          = 1'b0;
        bus.ht_build_last_processed = 1'b0;
        bus.s_probe_ready           = 1'b0;
        bus.ht_probe_valid          = 1'b0;
        bus.ht_probe_last_processed = 1'b0;
        case (state)
            S_IDLE: begin
                busy           = 1'b0;
                bus.ht_clear_n = 1'b0;
                if (start) begin
                    run_start  = 1'b1;
                    state_next = (cfg_num_parts == '0) ? S_DONE : S_CLEAR;
                end
            end
            S_CLEAR: begin
                bus.ht_clear_n = 1'b0;
                if (clr_cnt == '0) state_next = S_BUILD;
            end
            S_BUILD: begin
                bus.ht_build_valid = bus.s_build_valid;
                bus.s_build_ready  = bus.ht_build_ready;
                build_fire         = bus.s_build_valid & bus.ht_build_ready;
                if (build_fire && bus.s_build_last) state_next = S_BUILD_END;
            end
            // Last-processed is held until the engine can take it, in case it was still writing.
            S_BUILD_END: begin
                bus.ht_build_last_processed = 1'b1;
                if (bus.ht_build_ready) state_next = S_PROBE;
            end
            S_PROBE: begin
                bus.ht_probe_valid          = bus.s_probe_valid;
                bus.s_probe_ready           = bus.ht_probe_ready;
                bus.ht_probe_last_processed = bus.s_probe_valid & bus.s_probe_last;
                probe_fire                  = bus.s_probe_valid & bus.ht_probe_ready;
                if (probe_fire && bus.s_probe_last) state_next = S_DRAIN;
            end
            S_DRAIN: begin
                if (bus.ht_out_last_processed) begin
                    if (cur_part == num_parts - PART_W'(1)) begin
                        state_next = S_DONE;
                    end else begin
                        part_next  = 1'b1;
                        state_next = S_CLEAR;
                    end
                end
            end
            S_DONE: begin
                busy           = 1'b0;
                done           = 1'b1;
                bus.ht_clear_n = 1'b0;
                state_next     = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign match_fire = busy & bus.ht_out_valid & bus.ht_out_ready & bus.ht_out_was_joined;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            num_parts <= '0;
            cur_part  <= '0;
            clr_cnt   <= '0;
            build_cnt <= '0;
            probe_cnt <= '0;
            match_cnt <= '0;
        end else begin
            if (run_start) begin
                num_parts <= cfg_num_parts;
                cur_part  <= '0;
                build_cnt <= '0;
                probe_cnt <= '0;
                match_cnt <= '0;
            end else begin
                if (build_fire) build_cnt <= build_cnt + CNT_W'(1);
                if (probe_fire) probe_cnt <= probe_cnt + CNT_W'(1);
                if (match_fire) match_cnt <= match_cnt + CNT_W'(1);
                if (part_next)  cur_part  <= cur_part + PART_W'(1);
            end
            if (state_next == S_CLEAR && state != S_CLEAR)
                clr_cnt <= CLR_W'(CLEAR_CYCLES - 1);
            else if (state == S_CLEAR && clr_cnt != '0)
                clr_cnt <= clr_cnt - CLR_W'(1);
        end
    end

endmodule

// File: tb/tb_ht_phase_scheduler.sv
// Directed bench for ht_phase_scheduler: single and multi-partition runs, engine back-pressure,
// early probe traffic, an empty run and a mid-run reset, all against hand-computed values.
module tb_ht_phase_scheduler;

    logic        clk = 1'b0;
    logic        resetn;
    logic        start;
    logic [7:0]  cfg_num_parts;
    logic        busy, done;
    logic [7:0]  cur_part;
    logic [31:0] build_cnt, probe_cnt, match_cnt;

    int n_checks = 0;
    int n_fails  = 0;

    ht_phase_scheduler_if bus ();

    ht_phase_scheduler #(.PART_W(8), .CLEAR_CYCLES(2), .CNT_W(32)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .start         (start),
        .cfg_num_parts (cfg_num_parts),
        .bus           (bus),
        .busy          (busy),
        .done          (done),
        .cur_part      (cur_part),
        .build_cnt     (build_cnt),
        .probe_cnt     (probe_cnt),
        .match_cnt     (match_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        start = 1'b0; cfg_num_parts = '0;
        bus.s_build_valid = 1'b0; bus.s_build_data = '0; bus.s_build_hash = '0; bus.s_build_last = 1'b0;
        bus.s_probe_valid = 1'b0; bus.s_probe_data = '0; bus.s_probe_hash = '0;
        bus.s_probe_serial = '0; bus.s_probe_last = 1'b0;
        bus.ht_build_ready = 1'b1; bus.ht_probe_ready = 1'b1;
        bus.ht_out_valid = 1'b0; bus.ht_out_ready = 1'b1; bus.ht_out_was_joined = 1'b0;
        bus.ht_out_last_processed = 1'b0;
    endtask

    task automatic do_start(input logic [7:0] n);
        start = 1'b1; cfg_num_parts = n;
        tick();
        start = 1'b0; cfg_num_parts = 8'd0;
    endtask

    // Counts cycles with ht_clear_n low until the build phase opens.
    task automatic wait_clear(input int part);
        int low = 0;
        for (int i = 0; i < 10; i++) begin
            #2;
            if (bus.ht_clear_n == 1'b0) begin
                low++;
                @(posedge clk); #1;
            end else begin
                break;
            end
        end
        check("clear_low_cycles", low, 2);
        check("cur_part", cur_part, part);
    endtask

    task automatic send_build(input logic [63:0] d, input logic [31:0] h, input logic last);
        bit ok = 0;
        bus.s_build_valid = 1'b1; bus.s_build_data = d; bus.s_build_hash = h; bus.s_build_last = last;
        for (int i = 0; i < 20; i++) begin
            #2;
            check("probe_gated_in_build", {bus.s_probe_ready, bus.ht_probe_valid}, 0);
            if (bus.s_build_ready) begin
                check("ht_build_valid", bus.ht_build_valid, 1);
                check("ht_build_data", bus.ht_build_data, d);
                check("ht_build_hash", bus.ht_build_hash, h);
                ok = 1;
                @(posedge clk); #1;
                break;
            end
            @(posedge clk); #1;
        end
        if (!ok) check("build_timeout", 0, 1);
        bus.s_build_valid = 1'b0; bus.s_build_last = 1'b0;
    endtask

    task automatic send_probe(input logic [63:0] d, input logic [31:0] h, input logic [63:0] s,
                              input logic last);
        bit ok = 0;
        bus.s_probe_valid = 1'b1; bus.s_probe_data = d; bus.s_probe_hash = h;
        bus.s_probe_serial = s; bus.s_probe_last = last;
        for (int i = 0; i < 20; i++) begin
            #2;
            check("build_gated_in_probe", {bus.s_build_ready, bus.ht_build_valid}, 0);
            if (bus.s_probe_ready) begin
                check("ht_probe_valid", bus.ht_probe_valid, 1);
                check("ht_probe_data", bus.ht_probe_data, d);
                check("ht_probe_serial", bus.ht_probe_serial, s);
                check("ht_probe_last_processed", bus.ht_probe_last_processed, last);
                ok = 1;
                @(posedge clk); #1;
                break;
            end
            @(posedge clk); #1;
        end
        if (!ok) check("probe_timeout", 0, 1);
        bus.s_probe_valid = 1'b0; bus.s_probe_last = 1'b0;
    endtask

    task automatic drain();
        bus.ht_out_last_processed = 1'b1;
        #2;
        check("busy_in_drain", busy, 1);
        check("done_in_drain", done, 0);
        @(posedge clk); #1;
        bus.ht_out_last_processed = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        resetn = 1'b0;
        bus.s_build_valid = 1'b1;
        bus.s_probe_valid = 1'b1;
        #12;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_clear_n", bus.ht_clear_n, 0);
        check("rst_cur_part", cur_part, 0);
        check("rst_counters", {build_cnt, probe_cnt} | 64'(match_cnt), 0);
        check("rst_readys", {bus.s_build_ready, bus.s_probe_ready}, 0);
        check("rst_valids", {bus.ht_build_valid, bus.ht_probe_valid}, 0);
        check("rst_lasts", {bus.ht_build_last_processed, bus.ht_probe_last_processed}, 0);
        bus.s_build_valid = 1'b0;
        bus.s_probe_valid = 1'b0;
        resetn = 1'b1;
        tick();
        #2;
        check("idle_clear_n", bus.ht_clear_n, 0);

        // Single partition, engine stalls one cycle after the last build tuple, 2 matches.
        do_start(8'd1);
        wait_clear(0);
        send_build(64'h11, 32'hA1, 1'b0);
        send_build(64'h12, 32'hA2, 1'b0);
        send_build(64'h13, 32'hA3, 1'b1);
        bus.ht_build_ready = 1'b0;
        bus.s_build_valid  = 1'b1;
        #2;
        check("bend_last_stall", bus.ht_build_last_processed, 1);
        check("bend_valid_gated", bus.ht_build_valid, 0);
        check("bend_ready_gated", bus.s_build_ready, 0);
        tick();
        bus.ht_build_ready = 1'b1;
        bus.s_build_valid  = 1'b0;
        #2;
        check("bend_last_ready", bus.ht_build_last_processed, 1);
        check("bend_probe_closed", bus.s_probe_ready, 0);
        tick();
        #2;
        check("probe_last_dropped", bus.ht_build_last_processed, 0);
        check("probe_entered", bus.s_probe_ready, 1);
        send_probe(64'h21, 32'hB1, 64'd100, 1'b0);
        send_probe(64'h22, 32'hB2, 64'd101, 1'b0);
        send_probe(64'h23, 32'hB3, 64'd102, 1'b0);
        send_probe(64'h24, 32'hB4, 64'd103, 1'b1);
        bus.ht_out_valid = 1'b1; bus.ht_out_ready = 1'b1; bus.ht_out_was_joined = 1'b1;
        tick();
        bus.ht_out_ready = 1'b0;
        tick();
        bus.ht_out_ready = 1'b1; bus.ht_out_was_joined = 1'b0;
        tick();
        bus.ht_out_was_joined = 1'b1;
        drain();
        bus.ht_out_valid = 1'b0; bus.ht_out_was_joined = 1'b0;
        #2;
        check("p1_done", done, 1);
        check("p1_busy_in_done", busy, 0);
        check("p1_build_cnt", build_cnt, 3);
        check("p1_probe_cnt", probe_cnt, 4);
        check("p1_match_cnt", match_cnt, 2);
        check("p1_cur_part", cur_part, 0);
        tick();
        #2;
        check("p1_done_one_cycle", done, 0);
        check("p1_match_hold", match_cnt, 2);
        tick();

        // Three partitions; probe traffic is already waiting during each build phase.
        do_start(8'd3);
        for (int p = 0; p < 3; p++) begin
            wait_clear(p);
            bus.s_probe_valid  = 1'b1;
            bus.s_probe_data   = 64'h300 + 64'(p);
            bus.s_probe_hash   = 32'hC0;
            bus.s_probe_serial = 64'(p);
            send_build(64'h200 + 64'(2 * p), 32'hD0, 1'b0);
            send_build(64'h201 + 64'(2 * p), 32'hD1, 1'b1);
            send_probe(64'h300 + 64'(p), 32'hC0, 64'(p), 1'b0);
            send_probe(64'h310 + 64'(p), 32'hC1, 64'(p + 10), 1'b1);
            drain();
        end
        #2;
        check("p3_done", done, 1);
        check("p3_build_cnt", build_cnt, 6);
        check("p3_probe_cnt", probe_cnt, 6);
        check("p3_match_cnt", match_cnt, 0);
        check("p3_cur_part", cur_part, 2);
        tick();

        // Empty run: straight to DONE, no clear activity, counters zeroed.
        do_start(8'd0);
        #2;
        check("p0_done", done, 1);
        check("p0_busy", busy, 0);
        check("p0_clear_n", bus.ht_clear_n, 0);
        check("p0_build_cnt", build_cnt, 0);
        check("p0_probe_cnt", probe_cnt, 0);
        tick();
        #2;
        check("p0_done_one_cycle", done, 0);
        check("p0_clear_n_idle", bus.ht_clear_n, 0);
        tick();

        // Reset in the middle of the probe phase, then a clean run.
        do_start(8'd1);
        wait_clear(0);
        send_build(64'h41, 32'hE1, 1'b0);
        send_build(64'h42, 32'hE2, 1'b1);
        send_probe(64'h51, 32'hF1, 64'd1, 1'b0);
        send_probe(64'h52, 32'hF2, 64'd2, 1'b0);
        bus.s_probe_valid = 1'b1; bus.s_probe_data = 64'h53;
        #2;
        check("mid_probe_open", bus.s_probe_ready, 1);
        check("mid_probe_cnt", probe_cnt, 2);
        resetn = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_clear_n", bus.ht_clear_n, 0);
        check("arst_probe_gated", {bus.s_probe_ready, bus.ht_probe_valid}, 0);
        check("arst_counters", {build_cnt, probe_cnt}, 0);
        check("arst_cur_part", cur_part, 0);
        idle_inputs();
        tick();
        resetn = 1'b1;
        tick();
        do_start(8'd1);
        wait_clear(0);
        send_build(64'h61, 32'h71, 1'b1);
        send_probe(64'h81, 32'h91, 64'd7, 1'b1);
        drain();
        #2;
        check("rerun_done", done, 1);
        check("rerun_build_cnt", build_cnt, 1);
        check("rerun_probe_cnt", probe_cnt, 1);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
